// File: rtl/dds_phase_2ch.sv
// ---------------------------------------------------------------------------
// dds_phase_2ch
//
// Two-channel DDS phase accumulator that drives a 2-channel sine ROM.
// Channel A addresses the raw accumulator phase; channel B addresses the
// same phase plus a programmable offset (a quarter turn by default, which
// gives quadrature outputs).
//
// The tuning word and the offset are written through a valid/ready
// handshake into a one-entry shadow register. The shadow is committed
// either on the next sample tick (SYNC_UPDATE = 0) or on the next tick
// that wraps the phase, or on i_sync (SYNC_UPDATE = 1). This makes
// frequency and phase changes glitch-free.
//
// Ports
//   i_clk        clock, single domain
//   i_rst_n      asynchronous active-low reset
//   i_en         sample tick (one-cycle pulse); advances the phase
//   i_sync       synchronous phase clear; has priority over i_en
//   i_cfg_valid  config word valid
//   o_cfg_ready  shadow register free (registered)
//   i_cfg_sel    0 = tuning word, 1 = phase offset
//   i_cfg_data   config value
//   o_addr_a     channel A ROM address (registered)
//   o_addr_b     channel B ROM address (registered)
//   o_rom_en     ROM read enable pulse (registered)
//   o_wrap       accumulator overflowed on this update (registered)
// ---------------------------------------------------------------------------
module dds_phase_2ch #(
    parameter int                   ACC_WIDTH   = 16,
    parameter int                   ADDR_WIDTH  = 9,
    parameter logic [ACC_WIDTH-1:0] FTW_INIT    = 16'h0080,
    parameter logic [ACC_WIDTH-1:0] POFF_INIT   = 16'h4000,
    parameter bit                   SYNC_UPDATE = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_sync,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic                  i_cfg_sel,
    input  logic [ACC_WIDTH-1:0]  i_cfg_data,
    output logic [ADDR_WIDTH-1:0] o_addr_a,
    output logic [ADDR_WIDTH-1:0] o_addr_b,
    output logic                  o_rom_en,
    output logic                  o_wrap
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_B_INIT = POFF_INIT[ACC_WIDTH-1 -: ADDR_WIDTH];

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [ACC_WIDTH-1:0]    ftw_q, ftw_d;
    logic [ACC_WIDTH-1:0]    poff_q, poff_d;
    logic [ACC_WIDTH-1:0]    shadow_val_q, shadow_val_d;
    logic                    shadow_sel_q, shadow_sel_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
    logic                    rom_en_q, rom_en_d;
    logic                    wrap_q, wrap_d;
    logic                    cfg_ready_q, cfg_ready_d;

    logic                    xfer_s;
    logic                    commit_s;
    logic                    upd_wrap_s;
    logic [ACC_WIDTH:0]      sum_s;
    logic [ACC_WIDTH-1:0]    phase_b_s;

    // Handshake, carry-extended phase sum and the commit event.
    always_comb begin
        xfer_s     = i_cfg_valid & cfg_ready_q;
        sum_s      = {1'b0, acc_q} + {1'b0, ftw_q};
        // Only a real phase update (not a sync) can signal a wrap.
        upd_wrap_s = i_en & ~i_sync & sum_s[ACC_WIDTH];
        if (state_q == S_PENDING) begin
            commit_s = SYNC_UPDATE ? (i_sync | upd_wrap_s) : i_en;
        end else begin
            commit_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: accept in IDLE, wait for the commit in PENDING.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = xfer_s   ? S_PENDING : S_IDLE;
            S_PENDING: state_d = commit_s ? S_IDLE    : S_PENDING;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM output logic: ready is registered and reflects the state being entered.
    always_comb begin
        if (state_d == S_IDLE) begin
            cfg_ready_d = 1'b1;
        end else begin
            cfg_ready_d = 1'b0;
        end
    end

    // Shadow capture, config commit and the phase/address update.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_sel_d = shadow_sel_q;
        ftw_d        = ftw_q;
        poff_d       = poff_q;
        acc_d        = acc_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        rom_en_d     = 1'b0;
        wrap_d       = 1'b0;
        phase_b_s    = {ACC_WIDTH{1'b0}};

        if (xfer_s) begin
            shadow_val_d = i_cfg_data;
            shadow_sel_d = i_cfg_sel;
        end else begin
            shadow_val_d = shadow_val_q;
            shadow_sel_d = shadow_sel_q;
        end

        // A committed tuning word only affects the next tick (the sum above
        // already uses ftw_q), whereas a committed offset is used right away
        // because the channel-B address below is built from poff_d.
        if (commit_s) begin
            if (shadow_sel_q) begin
                poff_d = shadow_val_q;
            end else begin
                ftw_d = shadow_val_q;
            end
        end else begin
            ftw_d  = ftw_q;
            poff_d = poff_q;
        end

        if (i_sync) begin
            acc_d     = {ACC_WIDTH{1'b0}};
            phase_b_s = poff_d;
            addr_a_d  = {ADDR_WIDTH{1'b0}};
            addr_b_d  = phase_b_s[ACC_WIDTH-1 -: ADDR_WIDTH];
            rom_en_d  = 1'b1;
            wrap_d    = 1'b0;
        end else if (i_en) begin
            acc_d     = sum_s[ACC_WIDTH-1:0];
            phase_b_s = acc_d + poff_d;
            addr_a_d  = acc_d[ACC_WIDTH-1 -: ADDR_WIDTH];
            addr_b_d  = phase_b_s[ACC_WIDTH-1 -: ADDR_WIDTH];
            rom_en_d  = 1'b1;
            wrap_d    = sum_s[ACC_WIDTH];
        end else begin
            acc_d     = acc_q;
            addr_a_d  = addr_a_q;
            addr_b_d  = addr_b_q;
            rom_en_d  = 1'b0;
            wrap_d    = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q        <= {ACC_WIDTH{1'b0}};
            ftw_q        <= FTW_INIT;
            poff_q       <= POFF_INIT;
            shadow_val_q <= {ACC_WIDTH{1'b0}};
            shadow_sel_q <= 1'b0;
            addr_a_q     <= {ADDR_WIDTH{1'b0}};
            addr_b_q     <= ADDR_B_INIT;
            rom_en_q     <= 1'b0;
            wrap_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
        end else begin
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            poff_q       <= poff_d;
            shadow_val_q <= shadow_val_d;
            shadow_sel_q <= shadow_sel_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            rom_en_q     <= rom_en_d;
            wrap_q       <= wrap_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign o_cfg_ready = cfg_ready_q;
    assign o_addr_a    = addr_a_q;
    assign o_addr_b    = addr_b_q;
    assign o_rom_en    = rom_en_q;
    assign o_wrap      = wrap_q;

endmodule

// File: tb/tb_dds_phase_2ch.sv
// ---------------------------------------------------------------------------
// tb_dds_phase_2ch
//
// Two instances share clock, reset and stimulus: u_dut0 commits config on
// the next tick (SYNC_UPDATE = 0), u_dut1 commits on a phase wrap or
// i_sync (SYNC_UPDATE = 1). A table of directed vectors exercises u_dut0;
// hand-written sequences cover the wrap-synchronous commit, sync with
// tick, and reset while a config is pending.
// ---------------------------------------------------------------------------
module tb_dds_phase_2ch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, sync, cfg_valid, cfg_sel;
    logic [15:0] cfg_data;

    logic        ready0, rom0, wrap0;
    logic [8:0]  a0, b0;
    logic        ready1, rom1, wrap1;
    logic [8:0]  a1, b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dds_phase_2ch #(.ACC_WIDTH(16), .ADDR_WIDTH(9), .FTW_INIT(16'h0080),
                    .POFF_INIT(16'h4000), .SYNC_UPDATE(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync(sync),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(ready0), .i_cfg_sel(cfg_sel),
        .i_cfg_data(cfg_data), .o_addr_a(a0), .o_addr_b(b0),
        .o_rom_en(rom0), .o_wrap(wrap0)
    );

    dds_phase_2ch #(.ACC_WIDTH(16), .ADDR_WIDTH(9), .FTW_INIT(16'h0080),
                    .POFF_INIT(16'h4000), .SYNC_UPDATE(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync(sync),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(ready1), .i_cfg_sel(cfg_sel),
        .i_cfg_data(cfg_data), .o_addr_a(a1), .o_addr_b(b1),
        .o_rom_en(rom1), .o_wrap(wrap1)
    );

    typedef struct {
        logic        en;
        logic        sync;
        logic        valid;
        logic        sel;
        logic [15:0] data;
        int          a;
        int          b;
        logic        rom;
        logic        wrap;
        logic        ready;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic e, input logic s, input logic v,
                        input logic sl, input logic [15:0] d, input int a,
                        input int b, input logic r, input logic w, input logic rd);
        vecs[i].en    = e;
        vecs[i].sync  = s;
        vecs[i].valid = v;
        vecs[i].sel   = sl;
        vecs[i].data  = d;
        vecs[i].a     = a;
        vecs[i].b     = b;
        vecs[i].rom   = r;
        vecs[i].wrap  = w;
        vecs[i].ready = rd;
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cycle(input logic e, input logic s, input logic v,
                         input logic sl, input logic [15:0] d);
        en        = e;
        sync      = s;
        cfg_valid = v;
        cfg_sel   = sl;
        cfg_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = 1'b0;
        cfg_data  = 16'h0000;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
    endtask

    initial begin
        //   idx en sync vld sel data      a    b    rom  wrap rdy
        setv( 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   1, 129, 1'b1, 1'b0, 1'b1);
        setv( 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000,   1, 129, 1'b0, 1'b0, 1'b1);
        setv( 2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   2, 130, 1'b1, 1'b0, 1'b1);
        setv( 3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   3, 131, 1'b1, 1'b0, 1'b1);
        setv( 4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   4, 132, 1'b1, 1'b0, 1'b1);
        setv( 5, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4000,   4, 132, 1'b0, 1'b0, 1'b0);
        setv( 6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   5, 133, 1'b1, 1'b0, 1'b1);
        setv( 7, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000,   0, 128, 1'b1, 1'b0, 1'b1);
        setv( 8, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 128, 256, 1'b1, 1'b0, 1'b1);
        setv( 9, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 256, 384, 1'b1, 1'b0, 1'b1);
        setv(10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 384,   0, 1'b1, 1'b0, 1'b1);
        setv(11, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   0, 128, 1'b1, 1'b1, 1'b1);
        setv(12, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000,   0, 128, 1'b0, 1'b0, 1'b1);
        setv(13, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000,   0, 128, 1'b0, 1'b0, 1'b0);
        setv(14, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 128, 384, 1'b1, 1'b0, 1'b1);
        setv(15, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 256,   0, 1'b1, 1'b0, 1'b1);
        setv(16, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0080, 384, 128, 1'b1, 1'b0, 1'b0);
        setv(17, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 384, 128, 1'b0, 1'b0, 1'b0);
        setv(18, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   0, 256, 1'b1, 1'b1, 1'b1);
        setv(19, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   1, 257, 1'b1, 1'b0, 1'b1);
        setv(20, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000,   1, 257, 1'b0, 1'b0, 1'b0);
        setv(21, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   2, 258, 1'b1, 1'b0, 1'b1);
        setv(22, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,   2, 258, 1'b1, 1'b0, 1'b1);
        setv(23, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000,   2, 258, 1'b0, 1'b0, 1'b1);
        setv(24, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4000,   2, 258, 1'b0, 1'b0, 1'b0);
        setv(25, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000,   0, 128, 1'b1, 1'b0, 1'b1);

        // Reset state of both instances.
        do_reset();
        chk("rst addr_a0", a0, 0);
        chk("rst addr_b0", b0, 128);
        chk("rst rom_en0", rom0, 0);
        chk("rst wrap0", wrap0, 0);
        chk("rst ready0", ready0, 1);
        chk("rst addr_a1", a1, 0);
        chk("rst addr_b1", b1, 128);
        chk("rst ready1", ready1, 1);

        // Table-driven vectors against the next-tick commit instance.
        for (int i = 0; i < 26; i++) begin
            cycle(vecs[i].en, vecs[i].sync, vecs[i].valid, vecs[i].sel, vecs[i].data);
            chk($sformatf("v%0d addr_a", i), a0, vecs[i].a);
            chk($sformatf("v%0d addr_b", i), b0, vecs[i].b);
            chk($sformatf("v%0d rom_en", i), rom0, vecs[i].rom);
            chk($sformatf("v%0d wrap", i), wrap0, vecs[i].wrap);
            chk($sformatf("v%0d ready", i), ready1 === 1'bx ? 0 : ready0, vecs[i].ready);
        end

        // Wrap-synchronous commit: step stays 1 until the accumulator wraps.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("sync addr_a=10", a1, 10);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
        chk("sync accept ready", ready1, 0);
        for (int i = 11; i < 512; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
            chk($sformatf("sync step1 addr_a@%0d", i), a1, i);
            chk($sformatf("sync pend ready@%0d", i), ready1, 0);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("sync wrap addr_a", a1, 0);
        chk("sync wrap flag", wrap1, 1);
        chk("sync wrap addr_b", b1, 128);
        chk("sync commit ready", ready1, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("sync step2 addr_a", a1, 2);
        chk("sync step2 addr_b", b1, 130);
        chk("sync step2 wrap", wrap1, 0);
        // Offset committed by i_sync alone.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        chk("poff pend ready", ready1, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("poff sync addr_a", a1, 0);
        chk("poff sync addr_b", b1, 0);
        chk("poff sync rom_en", rom1, 1);
        chk("poff sync ready", ready1, 1);

        // i_sync together with i_en at acc = 16'h1234.
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("s+e old ftw addr_a", a0, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("s+e clear addr_a", a0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("s+e 1234 addr_a", a0, 36);
        chk("s+e 1234 addr_b", b0, 164);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("s+e addr_a", a0, 0);
        chk("s+e addr_b", b0, 128);
        chk("s+e wrap", wrap0, 0);
        chk("s+e rom_en", rom0, 1);

        // Reset while a config is pending and i_cfg_valid is held.
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h4000);
        chk("rp accept ready0", ready0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h4000);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h4000);
        chk("rp held ready0", ready0, 0);
        chk("rp held ready1", ready1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rp in-reset ready0", ready0, 1);
        cfg_valid = 1'b0;
        rst_n     = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("rp tick1 addr_a0", a0, 1);
        chk("rp tick1 addr_b0", b0, 129);
        chk("rp tick1 ready0", ready0, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("rp tick2 addr_a0", a0, 2);
        chk("rp tick2 addr_a1", a1, 2);
        chk("rp tick2 ready1", ready1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_phase_2ch.md
# dds_phase_2ch

Two-channel DDS phase accumulator that generates the read addresses and read enable for the 2-channel sine ROM feeding the sigma-delta modulators. Channel A is the raw accumulator phase. Channel B is the same phase plus a programmable offset; the default offset is a quarter turn, giving quadrature outputs. The tuning word and offset are loaded through a valid/ready handshake and committed either on the next sample tick or on the next phase wrap, so frequency and phase changes are glitch-free.

## Interface
- ACC_WIDTH, 16, phase accumulator width (ACC_WIDTH > ADDR_WIDTH)
- ADDR_WIDTH, 9, ROM address width; addresses are acc[ACC_WIDTH-1 -: ADDR_WIDTH]
- FTW_INIT, 16'h0080, tuning word after reset
- POFF_INIT, 16'h4000, channel-B phase offset after reset
- SYNC_UPDATE, 1, 1 = commit config at phase wrap; 0 = commit at next tick
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  sample tick, one-cycle pulse; advances phase
- i_sync  in  1  synchronous phase clear
- i_cfg_valid  in  1  config word valid
- o_cfg_ready  out  1  config register free
- i_cfg_sel  in  1  0 = tuning word, 1 = phase offset
- i_cfg_data  in  ACC_WIDTH  config value
- o_addr_a  out  ADDR_WIDTH  channel A ROM address
- o_addr_b  out  ADDR_WIDTH  channel B ROM address
- o_rom_en  out  1  ROM read enable, one-cycle pulse
- o_wrap  out  1  pulse: accumulator overflowed on this update

## Operation
- Registers:
  - acc: phase accumulator.
  - ftw, poff: active tuning word and phase offset.
  - shadow value and shadow sel: pending config.
  - state: IDLE or PENDING.
- Reset values: acc = 0, ftw = FTW_INIT, poff = POFF_INIT, state = IDLE, o_cfg_ready = 1, o_addr_a = 0, o_addr_b = POFF_INIT MSBs, o_rom_en = 0, o_wrap = 0.
- Handshake: a transfer occurs when i_cfg_valid & o_cfg_ready are high on the same edge. On a transfer, the shadow captures data and sel, the state goes IDLE→PENDING, and o_cfg_ready drops on the next cycle. i_cfg_valid while in PENDING is ignored; the data is held off and not lost.
- Commit in PENDING:
  - The shadow is copied into ftw or poff at the commit event, and the state returns to IDLE, with o_cfg_ready = 1 on the next cycle.
  - Commit event with SYNC_UPDATE=0: the next i_en.
  - Commit event with SYNC_UPDATE=1: the next i_en whose update wraps, or i_sync.
  - A committed ftw is first used on the following tick. A committed poff is used on the same update (it applies to o_addr_b immediately).
- Phase update on an i_en cycle with i_sync = 0:
  - sum = acc + ftw, computed ACC_WIDTH+1 wide.
  - acc <= sum[ACC_WIDTH-1:0].
  - o_wrap <= sum[ACC_WIDTH].
  - o_addr_a <= MSBs of the new acc.
  - o_addr_b <= MSBs of (new acc + poff), taken modulo 2^ACC_WIDTH.
  - o_rom_en <= 1.
- i_sync, regardless of i_en:
  - acc <= 0 and o_wrap <= 0.
  - o_addr_a <= 0 and o_addr_b <= poff MSBs (using the committed poff if a commit happens in that cycle).
  - o_rom_en <= 1.
  - i_sync has priority over i_en.
- Idle cycle (no i_en, no i_sync): acc and the addresses hold; o_rom_en and o_wrap = 0.
- ftw = 0 is legal: the addresses freeze, but o_rom_en still pulses on every tick.
- Reset asserted mid-PENDING discards the shadow and restores the init values.

## Timing
- Latency: i_en at edge N → o_addr_*, o_rom_en, o_wrap valid after edge N+1. ROM data is valid after edge N+2.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Back-to-back ticks (i_en high every cycle) are supported at one update per clock.
- Throughput: one config transfer per two cycles minimum (accept, then commit).
- Handshake and tick in the same cycle: the transfer is captured, but the commit waits for a later event. A config never commits on the cycle it is accepted.

## Test plan
- Reset, defaults: 4 ticks → o_addr_a = 1,2,3,4; o_addr_b = 129,130,131,132; o_rom_en pulses once per tick, 1 cycle late.
- Wrap: load ftw 16'h4000 with SYNC_UPDATE=0 → o_addr_a = 128,256,384,0; o_wrap = 1 only on the 0 update.
- Synchronous update: SYNC_UPDATE=1, ftw 16'h0080, load ftw 16'h0100 at o_addr_a = 10 → the step stays 1 until the wrap. o_cfg_ready stays 0 until the commit.
- Offset: load poff 16'h8000 (SYNC_UPDATE=0) → on the commit tick o_addr_b = o_addr_a + 256 mod 512.
- i_sync together with i_en at acc = 16'h1234 → o_addr_a = 0, o_addr_b = 128, o_wrap = 0, o_rom_en = 1.
- i_cfg_valid held during PENDING, then reset → o_cfg_ready = 1, ftw = 16'h0080, no stale commit.
